// File: rtl/dds.sv
// Quadrature DDS: phase accumulator + elaboration-time sine table -> registered sin/cos, offset binary.
// Latency: pword reaches outputs at the next edge; fword reaches outputs two edges later (via acc).
// No backpressure: one sample per clock. DDS_QUARTER_WAVE_EN selects a quarter-wave table with quadrant decode.
module dds #(
   parameter int DEPTH_BITWIDTH = 8,
   parameter int DATA_BITWIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DEPTH_BITWIDTH-1:0] pword,
   input  logic [DEPTH_BITWIDTH-1:0] fword,
   output logic [DATA_BITWIDTH-1:0]  cos,
   output logic [DATA_BITWIDTH-1:0]  sin
);

   localparam int  N   = 1 << DEPTH_BITWIDTH;
   localparam int  MID = 1 << (DATA_BITWIDTH - 1);
   localparam int  AMP = MID - 1;
   localparam real PI  = 3.14159265358979323846;

   localparam logic [DATA_BITWIDTH-1:0]  MID_CODE = DATA_BITWIDTH'(MID);
   localparam logic [DEPTH_BITWIDTH-1:0] QTR      = DEPTH_BITWIDTH'(N / 4);

   // Signed table amplitude for index k, rounded half away from zero so that
   // mirrored indices give exactly mirrored codes (keeps both table forms identical).
   function automatic int scaled_sin(input int k);
      real x;
      x = real'(AMP) * $sin(2.0 * PI * real'(k) / real'(N));
      if (x >= 0.0) return $rtoi(x + 0.5);
      else          return -$rtoi(-x + 0.5);
   endfunction

   logic [DEPTH_BITWIDTH-1:0] acc;

   // Lane 0 addresses the sine phase, lane 1 the cosine phase (quarter turn ahead).
   logic [1:0][DEPTH_BITWIDTH-1:0] ph;
   logic [1:0][DATA_BITWIDTH-1:0]  smp;

   assign ph[0] = acc + pword;
   assign ph[1] = acc + pword + QTR;

`ifdef DDS_QUARTER_WAVE_EN
   localparam logic [DEPTH_BITWIDTH-1:0] HALF = DEPTH_BITWIDTH'(N / 2);

   // Magnitudes for k = 0..N/4; sized N/2 so any (DEPTH_BITWIDTH-1)-bit index is in range.
   logic [DATA_BITWIDTH-2:0] qtbl [N/2];

   for (genvar k = 0; k < N/2; k++) begin : g_qtbl
      localparam logic [DATA_BITWIDTH-2:0] QV =
         (k <= N/4) ? (DATA_BITWIDTH-1)'(scaled_sin(k)) : '0;
      assign qtbl[k] = QV;
   end

   for (genvar l = 0; l < 2; l++) begin : g_lane
      logic [1:0]                qd;
      logic [DEPTH_BITWIDTH-2:0] off;
      logic [DATA_BITWIDTH-2:0]  mag;

      // Fold the phase into the first quadrant and restore the sign from the upper quadrant bit.
      always_comb begin
         qd = ph[l][DEPTH_BITWIDTH-1 -: 2];
         case (qd)
            2'd0:    off = (DEPTH_BITWIDTH-1)'(ph[l]);
            2'd1:    off = (DEPTH_BITWIDTH-1)'(HALF - ph[l]);
            2'd2:    off = (DEPTH_BITWIDTH-1)'(ph[l] - HALF);
            default: off = (DEPTH_BITWIDTH-1)'(-ph[l]);
         endcase
         mag    = qtbl[off];
         smp[l] = qd[1] ? (MID_CODE - {1'b0, mag}) : (MID_CODE + {1'b0, mag});
      end
   end
`else
   logic [DATA_BITWIDTH-1:0] tbl [N];

   for (genvar k = 0; k < N; k++) begin : g_tbl
      localparam logic [DATA_BITWIDTH-1:0] TV = DATA_BITWIDTH'(MID + scaled_sin(k));
      assign tbl[k] = TV;
   end

   for (genvar l = 0; l < 2; l++) begin : g_lane
      // Direct full-period table lookup.
      always_comb begin
         smp[l] = tbl[ph[l]];
      end
   end
`endif

   // Advance the accumulator and register both samples; reset parks outputs at midscale.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         sin <= MID_CODE;
         cos <= MID_CODE;
      end else begin
         acc <= acc + fword;
         sin <= smp[0];
         cos <= smp[1];
      end
   end

endmodule

// File: tb/tb_dds.sv
module tb_dds;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pword = 8'd0;
   logic [7:0] fword = 8'd0;
   logic [7:0] cos;
   logic [7:0] sin;

   int checks = 0;
   int errors = 0;

   dds #(.DEPTH_BITWIDTH(8), .DATA_BITWIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .pword (pword),
      .fword (fword),
      .cos   (cos),
      .sin   (sin)
   );

   always #5 clk = ~clk;

   // Reference sample: 128 + round_half_away(127*sin(2*pi*k/256)).
   function automatic logic [7:0] tref(input int k);
      real v;
      int  r;
      v = 127.0 * $sin(6.283185307179586 * real'(k % 256) / 256.0);
      r = (v < 0.0) ? -$rtoi(0.5 - v) : $rtoi(v + 0.5);
      return 8'(128 + r);
   endfunction

   // One rising edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] s_exp, input logic [7:0] c_exp);
      checks++;
      if (sin !== s_exp || cos !== c_exp) begin
         errors++;
         $display("FAIL %s: sin=%0d cos=%0d expected sin=%0d cos=%0d", name, sin, cos, s_exp, c_exp);
      end
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      pword = 8'd0;
      fword = 8'd2;
      rst   = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (i == 0 || i == 49) chk("reset_mid", 8'd128, 8'd128);
      end
   endtask

   task automatic test_sweep_fword2();
      rst = 1'b0;
      for (int n = 1; n <= 129; n++) begin
         tick();
         case (n)
            1:   chk("f2_edge1",   8'd128, 8'd255);
            33:  chk("f2_edge33",  8'd255, 8'd128);
            65:  chk("f2_edge65",  8'd128, 8'd1);
            97:  chk("f2_edge97",  8'd1,   8'd128);
            129: chk("f2_edge129", 8'd128, 8'd255);
            default: ;
         endcase
      end
   endtask

   task automatic test_hold();
      do_reset(2);
      fword = 8'd0;
      pword = 8'd64;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_p64", 8'd255, 8'd128);
      end
   endtask

   task automatic test_reverse();
      do_reset(2);
      fword = 8'd255;
      pword = 8'd0;
      tick(); chk("rev_edge1", 8'd128, 8'd255);
      tick(); chk("rev_edge2", 8'd125, 8'd255);
      tick(); chk("rev_edge3", 8'd122, tref(62));
   endtask

   task automatic test_pword_sweep();
      do_reset(2);
      fword = 8'd0;
      for (int k = 0; k < 256; k++) begin
         pword = 8'(k);
         tick();
         chk("pw_sweep", tref(k), tref(k + 64));
         case (k)
            0:   chk("T0",   8'd128, 8'd255);
            1:   chk("T1",   8'd131, tref(65));
            64:  chk("T64",  8'd255, 8'd128);
            128: chk("T128", 8'd128, 8'd1);
            192: chk("T192", 8'd1,   8'd128);
            default: ;
         endcase
      end
   endtask

   task automatic test_mid_reset();
      do_reset(2);
      fword = 8'd2;
      pword = 8'd10;
      repeat (20) tick();
      chk("mr_run", tref(48), tref(112));
      rst = 1'b1;
      tick();
      chk("mr_rst", 8'd128, 8'd128);
      rst = 1'b0;
      tick();
      chk("mr_after1", tref(10), tref(74));
      tick();
      chk("mr_after2", tref(12), tref(76));
   endtask

   task automatic test_random();
      logic [7:0] macc;
      logic [7:0] pw;
      do_reset(2);
      macc = 8'd0;
      for (int i = 0; i < 400; i++) begin
         pw    = 8'($urandom_range(0, 255));
         pword = pw;
         fword = 8'($urandom_range(0, 255));
         tick();
         chk("random", tref(int'(8'(macc + pw))), tref(int'(8'(macc + pw + 8'd64))));
         macc = macc + fword;
      end
   endtask

   initial begin
      test_reset();
      test_sweep_fword2();
      test_hold();
      test_reverse();
      test_pword_sweep();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dds.md
Name: dds

Overview:
- Direct digital synthesizer producing quadrature sine/cosine samples from a phase accumulator and an elaboration-time lookup table.
- A frequency word sets the per-cycle phase step; a phase word adds a static/dynamic phase offset.
- Used as a local oscillator/test-tone source feeding mixers and DAC paths; one sample per clock.

Parameters:
- DEPTH_BITWIDTH, 8, phase width; table depth N = 2^DEPTH_BITWIDTH; must be >= 2.
- DATA_BITWIDTH, 8, output sample width, unsigned offset-binary; must be >= 2.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- pword  input  DEPTH_BITWIDTH  phase offset word, unsigned, in units of 2π/N.
- fword  input  DEPTH_BITWIDTH  frequency (phase-step) word, unsigned, added to accumulator every cycle.
- cos  output  DATA_BITWIDTH  cosine sample, offset binary, registered.
- sin  output  DATA_BITWIDTH  sine sample, offset binary, registered.

Behaviour:
- Constants: M = 2^(DATA_BITWIDTH-1) (midscale), A = M-1 (amplitude).
- Table value for index k in 0..N-1: T[k] = M + R(A*sin(2πk/N)); R = round half away from zero. Range 1..2M-1; code 0 never produced.
- Table computed at elaboration (constant function/generate). No external memory file, no runtime writes.
- State: accumulator acc, DEPTH_BITWIDTH bits, wraps modulo N (carry discarded).
- Phase p = (acc + pword) mod N, combinational.
- Every rising edge with rst=1: acc <= 0; sin <= M; cos <= M.
- Every rising edge with rst=0: sin <= T[p]; cos <= T[(p + N/4) mod N]; acc <= acc + fword (mod N).
- Consequence: on edge n after reset release (n = 1, 2, ...), sin = T[((n-1)*fword + pword) mod N].
- Latency: pword change appears at the next edge. fword change affects acc at the next edge, so outputs change one edge later.
- Wrap: acc and p wrap silently. fword = N-1 is a step of -1 (reverse rotation).
- fword = 0 holds a constant output set by acc + pword.
- Output frequency = fclk*fword/N. fword > N/2 aliases; no checking.
- Reset mid-operation: next edge forces M/M and clears acc, regardless of pword/fword.
- No handshake; outputs are valid every cycle after the first post-reset edge.

Optional Feature:
- Macro DDS_QUARTER_WAVE_EN.
- Defined: table stores only Q[k] = R(A*sin(2πk/N)) for k = 0..N/4.
  - Quadrant decode of index i: quadrant 0 -> M+Q[i]; quadrant 1 -> M+Q[N/2-i]; quadrant 2 -> M-Q[i-N/2]; quadrant 3 -> M-Q[N-i].
  - Requires DEPTH_BITWIDTH >= 2.
- Not defined: full N-entry table T.
- Both builds give bit-identical outputs and identical latency for every input sequence. Symmetric rounding guarantees this.

Test Plan:
- Defaults, rst=1 for 50 cycles then 0, pword=0, fword=2 -> during reset sin=cos=128. Edge 1: sin=128, cos=255. Edge 33: sin=255, cos=128. Edge 65: sin=128, cos=1. Edge 97: sin=1, cos=128. Period 128 cycles.
- fword=0, pword=64 after reset -> sin=255, cos=128 constant every cycle.
- fword=255 (step -1), pword=0 -> sin sequence 128, 125, ... (T[255]=125, T[254]=122). Accumulator wraps 0->255.
- Sweep pword 0..255 with fword=0 -> sin matches T[k] at next edge. Check T[0]=128, T[64]=255, T[128]=128, T[192]=1, T[1]=131, and cos = T[(k+64) mod 256].
- Assert rst for one edge mid-run with fword=2 -> that edge outputs 128/128. Following edge outputs T[pword], T[pword+64], i.e. acc restarted at 0.
- Rebuild with DDS_QUARTER_WAVE_EN; rerun all scenarios, including random pword/fword changes every cycle -> output streams bit-identical to the non-macro build.
